// File: rtl/mcht_tx_arb.sv
// Two-requester round-robin frame arbiter feeding a single transmitter.
// Grants in IDLE, pulses TX_VLD in SEND, waits for TX_DNE (or times out), then idles pGAP_CYC cycles.
module mcht_tx_arb #(
  parameter int pMSG_LEN = 8,
  parameter int pGAP_CYC = 3,
  parameter int pTMO_CYC = 255
) (
  input  logic                CLK_25M,
  input  logic                RST_N,
  input  logic [1:0]          REQ_VLD,
  input  logic [pMSG_LEN-1:0] REQ_MSG0,
  input  logic [pMSG_LEN-1:0] REQ_MSG1,
  output logic [1:0]          REQ_ACK,
  input  logic                HALT,
  input  logic                ERR_CLR,
  output logic                TX_VLD,
  output logic [pMSG_LEN-1:0] TX_MSG,
  input  logic                TX_DNE,
  output logic                BUSY,
  output logic                GNT_ID,
  output logic                TMO_ERR,
  output logic [7:0]          SENT_CNT
);

  localparam int TW = (pTMO_CYC > 1) ? $clog2(pTMO_CYC) : 1;
  localparam int GW = (pGAP_CYC > 1) ? $clog2(pGAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t        state;
  logic          last;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic          grant;
  logic          gnt_sel;
  logic          tmo_hit;
  logic          tmo_set;
  state_t        post_wait;

  // On a tie the requester that did not win last time goes first.
  assign gnt_sel   = (REQ_VLD == 2'b11) ? ~last : REQ_VLD[1];
  assign grant     = (state == IDLE) && !HALT && (REQ_VLD != 2'b00);
  assign tmo_hit   = (timer == TW'(pTMO_CYC - 1));
  assign tmo_set   = (state == WAIT) && !TX_DNE && tmo_hit;
  assign post_wait = (pGAP_CYC == 0) ? IDLE : GAP;

  // The ack is a same-cycle handshake; gating with RST_N keeps it quiet during reset.
  assign REQ_ACK = (grant && RST_N) ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign TX_VLD  = (state == SEND);
  assign BUSY    = (state != IDLE);

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      last     <= 1'b1;
      timer    <= '0;
      gap_cnt  <= '0;
      TX_MSG   <= '0;
      GNT_ID   <= 1'b0;
      TMO_ERR  <= 1'b0;
      SENT_CNT <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            TX_MSG <= gnt_sel ? REQ_MSG1 : REQ_MSG0;
            GNT_ID <= gnt_sel;
            last   <= gnt_sel;
            state  <= SEND;
          end
        end
        SEND: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // TX_DNE takes priority over a timeout landing in the same cycle.
          if (TX_DNE) begin
            SENT_CNT <= SENT_CNT + 8'h01;
            gap_cnt  <= '0;
            state    <= post_wait;
          end else if (tmo_hit) begin
            gap_cnt  <= '0;
            state    <= post_wait;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(pGAP_CYC - 1)) state <= IDLE;
          else                              gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (tmo_set)      TMO_ERR <= 1'b1;
      else if (ERR_CLR) TMO_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcht_tx_arb.sv
// Directed bench for mcht_tx_arb: a per-cycle vector table plus hand-written
// sequences for timeout, HALT, counter wrap and mid-frame reset.
module tb_mcht_tx_arb;

  logic       CLK_25M = 1'b0;
  logic       RST_N   = 1'b0;
  logic [1:0] REQ_VLD = 2'b00;
  logic [7:0] REQ_MSG0 = 8'h00;
  logic [7:0] REQ_MSG1 = 8'h00;
  logic [1:0] REQ_ACK;
  logic       HALT    = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic       TX_VLD;
  logic [7:0] TX_MSG;
  logic       TX_DNE  = 1'b0;
  logic       BUSY;
  logic       GNT_ID;
  logic       TMO_ERR;
  logic [7:0] SENT_CNT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK_25M = ~CLK_25M;

  mcht_tx_arb #(.pMSG_LEN(8), .pGAP_CYC(3), .pTMO_CYC(255)) dut (
    .CLK_25M(CLK_25M), .RST_N(RST_N), .REQ_VLD(REQ_VLD),
    .REQ_MSG0(REQ_MSG0), .REQ_MSG1(REQ_MSG1), .REQ_ACK(REQ_ACK),
    .HALT(HALT), .ERR_CLR(ERR_CLR), .TX_VLD(TX_VLD), .TX_MSG(TX_MSG),
    .TX_DNE(TX_DNE), .BUSY(BUSY), .GNT_ID(GNT_ID), .TMO_ERR(TMO_ERR),
    .SENT_CNT(SENT_CNT)
  );

  typedef struct {
    logic [1:0] vld;
    logic [7:0] m0, m1;
    logic       halt, dne;
    logic [1:0] ack;
    logic       txv, busy, gnt;
    logic [7:0] msg, cnt;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t v(input logic [1:0] vl, input logic [7:0] a, input logic [7:0] b,
                             input logic h, input logic d, input logic [1:0] ak,
                             input logic tv, input logic bz, input logic g,
                             input logic [7:0] ms, input logic [7:0] ct);
    vec_t r;
    r.vld = vl; r.m0 = a; r.m1 = b; r.halt = h; r.dne = d;
    r.ack = ak; r.txv = tv; r.busy = bz; r.gnt = g; r.msg = ms; r.cnt = ct;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0; REQ_VLD = 2'b00; REQ_MSG0 = 8'h00; REQ_MSG1 = 8'h00;
    HALT = 1'b0; ERR_CLR = 1'b0; TX_DNE = 1'b0;
    repeat (2) @(negedge CLK_25M);
    RST_N = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (BUSY !== 1'b0 && n < max) begin
      @(negedge CLK_25M);
      n++;
    end
    chk("wait_idle", BUSY, 0);
  endtask

  // Entered at a negedge in IDLE; leaves at the negedge of the first post-WAIT cycle.
  task automatic frame(input logic [1:0] vl, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] eack, input logic [7:0] emsg, input int dly,
                       input string nm);
    REQ_VLD = vl; REQ_MSG0 = a; REQ_MSG1 = b;
    #1 chk({nm, "_ack"}, REQ_ACK, eack);
    @(negedge CLK_25M);
    REQ_VLD = 2'b00; REQ_MSG0 = 8'h00; REQ_MSG1 = 8'h00;
    #1 chk({nm, "_txv"}, TX_VLD, 1);
    chk({nm, "_msg"}, TX_MSG, emsg);
    repeat (dly) @(negedge CLK_25M);
    TX_DNE = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b0;
  endtask

  initial begin
    tbl[0]  = v(2'b11, 8'hA5, 8'h3C, 0, 0, 2'b01, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = v(2'b00, 8'hFF, 8'hFF, 0, 0, 2'b00, 1, 1, 0, 8'hA5, 8'h00);
    tbl[2]  = v(2'b00, 8'h00, 8'h00, 0, 1, 2'b00, 0, 1, 0, 8'hA5, 8'h00);
    tbl[3]  = v(2'b11, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 0, 8'hA5, 8'h01);
    tbl[4]  = v(2'b11, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 0, 8'hA5, 8'h01);
    tbl[5]  = v(2'b11, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 0, 8'hA5, 8'h01);
    tbl[6]  = v(2'b11, 8'h11, 8'h22, 0, 0, 2'b10, 0, 0, 0, 8'hA5, 8'h01);
    tbl[7]  = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1, 1, 1, 8'h22, 8'h01);
    tbl[8]  = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h22, 8'h01);
    tbl[9]  = v(2'b00, 8'h00, 8'h00, 0, 1, 2'b00, 0, 1, 1, 8'h22, 8'h01);
    tbl[10] = v(2'b01, 8'h00, 8'h00, 0, 1, 2'b00, 0, 1, 1, 8'h22, 8'h02);
    tbl[11] = v(2'b01, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h22, 8'h02);
    tbl[12] = v(2'b01, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h22, 8'h02);
    tbl[13] = v(2'b10, 8'h00, 8'h77, 0, 0, 2'b10, 0, 0, 1, 8'h22, 8'h02);
    tbl[14] = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1, 1, 1, 8'h77, 8'h02);
    tbl[15] = v(2'b00, 8'h00, 8'h00, 0, 1, 2'b00, 0, 1, 1, 8'h77, 8'h02);
    tbl[16] = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h77, 8'h03);
    tbl[17] = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h77, 8'h03);
    tbl[18] = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 1, 1, 8'h77, 8'h03);
    tbl[19] = v(2'b11, 8'h00, 8'h00, 1, 0, 2'b00, 0, 0, 1, 8'h77, 8'h03);
    tbl[20] = v(2'b11, 8'h00, 8'h00, 1, 1, 2'b00, 0, 0, 1, 8'h77, 8'h03);
    tbl[21] = v(2'b11, 8'h5A, 8'h00, 0, 0, 2'b01, 0, 0, 1, 8'h77, 8'h03);
    tbl[22] = v(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1, 1, 0, 8'h5A, 8'h03);

    // reset values while RST_N is held low
    REQ_VLD = 2'b11;
    @(negedge CLK_25M);
    #1;
    chk("rst_ack", REQ_ACK, 0);  chk("rst_txv", TX_VLD, 0);
    chk("rst_busy", BUSY, 0);    chk("rst_msg", TX_MSG, 0);
    chk("rst_gnt", GNT_ID, 0);   chk("rst_tmo", TMO_ERR, 0);
    chk("rst_cnt", SENT_CNT, 0);
    do_reset();

    // per-cycle vector table
    for (int i = 0; i < 23; i++) begin
      REQ_VLD = tbl[i].vld; REQ_MSG0 = tbl[i].m0; REQ_MSG1 = tbl[i].m1;
      HALT = tbl[i].halt; TX_DNE = tbl[i].dne;
      #1;
      chk($sformatf("vec%0d_ack", i), REQ_ACK, tbl[i].ack);
      chk($sformatf("vec%0d_txv", i), TX_VLD, tbl[i].txv);
      chk($sformatf("vec%0d_busy", i), BUSY, tbl[i].busy);
      chk($sformatf("vec%0d_gnt", i), GNT_ID, tbl[i].gnt);
      chk($sformatf("vec%0d_msg", i), TX_MSG, tbl[i].msg);
      chk($sformatf("vec%0d_cnt", i), SENT_CNT, tbl[i].cnt);
      chk($sformatf("vec%0d_tmo", i), TMO_ERR, 0);
      @(negedge CLK_25M);
    end

    // tie after reset, TX_DNE 10 cycles after each TX_VLD
    do_reset();
    frame(2'b11, 8'hA5, 8'h3C, 2'b01, 8'hA5, 10, "tie0");
    wait_idle(10);
    frame(2'b11, 8'hA5, 8'h3C, 2'b10, 8'h3C, 10, "tie1");
    wait_idle(10);
    chk("tie_cnt", SENT_CNT, 2);
    chk("tie_tmo", TMO_ERR, 0);

    // timeout, with ERR_CLR colliding with the set
    do_reset();
    REQ_VLD = 2'b01; REQ_MSG0 = 8'hC3;
    #1 chk("tmo_ack", REQ_ACK, 2'b01);
    @(negedge CLK_25M);
    REQ_VLD = 2'b00;
    #1 chk("tmo_txv", TX_VLD, 1);
    repeat (255) @(negedge CLK_25M);
    ERR_CLR = 1'b1;
    #1 chk("tmo_w255_err", TMO_ERR, 0);
    chk("tmo_w255_busy", BUSY, 1);
    @(negedge CLK_25M);
    ERR_CLR = 1'b0;
    #1 chk("tmo_set_wins", TMO_ERR, 1);
    chk("tmo_gap_busy", BUSY, 1);
    repeat (2) @(negedge CLK_25M);
    #1 chk("tmo_gap3_busy", BUSY, 1);
    @(negedge CLK_25M);
    #1 chk("tmo_idle_busy", BUSY, 0);
    chk("tmo_sticky", TMO_ERR, 1);
    chk("tmo_cnt", SENT_CNT, 0);
    ERR_CLR = 1'b1;
    @(negedge CLK_25M);
    ERR_CLR = 1'b0;
    #1 chk("tmo_clr", TMO_ERR, 0);

    // TX_DNE on the 255th WAIT cycle
    REQ_VLD = 2'b01; REQ_MSG0 = 8'h5C;
    @(negedge CLK_25M);
    REQ_VLD = 2'b00;
    #1 chk("race_txv", TX_VLD, 1);
    repeat (255) @(negedge CLK_25M);
    TX_DNE = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b0;
    #1 chk("race_cnt", SENT_CNT, 1);
    chk("race_tmo", TMO_ERR, 0);
    chk("race_busy", BUSY, 1);
    wait_idle(10);

    // HALT raised in WAIT
    REQ_VLD = 2'b11; REQ_MSG0 = 8'hD1; REQ_MSG1 = 8'hD2;
    #1 chk("halt_ack0", REQ_ACK, 2'b10);
    @(negedge CLK_25M);
    @(negedge CLK_25M);
    HALT = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("halt_noack%0d", k), REQ_ACK, 0);
      @(negedge CLK_25M);
    end
    #1 chk("halt_idle", BUSY, 0);
    chk("halt_cnt", SENT_CNT, 2);
    HALT = 1'b0;
    #1 chk("halt_release_ack", REQ_ACK, 2'b01);
    @(negedge CLK_25M);
    REQ_VLD = 2'b00;
    #1 chk("halt_release_txv", TX_VLD, 1);
    chk("halt_release_msg", TX_MSG, 8'hD1);
    @(negedge CLK_25M);
    TX_DNE = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b0;
    wait_idle(10);

    // 256 frames wrap SENT_CNT
    do_reset();
    for (int i = 0; i < 256; i++) begin
      frame(2'b01, 8'(i), 8'h00, 2'b01, 8'(i), 1, "wrap");
      wait_idle(10);
      if (i == 254) chk("wrap_255", SENT_CNT, 8'hFF);
    end
    chk("wrap_0", SENT_CNT, 8'h00);

    // reset in WAIT while requester 1 holds the frame
    REQ_VLD = 2'b11; REQ_MSG0 = 8'h34; REQ_MSG1 = 8'h56;
    #1 chk("mrst_ack1", REQ_ACK, 2'b10);
    @(negedge CLK_25M);
    #1 chk("mrst_msg1", TX_MSG, 8'h56);
    @(negedge CLK_25M);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_busy", BUSY, 0);    chk("mrst_txv", TX_VLD, 0);
    chk("mrst_msg", TX_MSG, 0);   chk("mrst_ack", REQ_ACK, 0);
    chk("mrst_gnt", GNT_ID, 0);   chk("mrst_cnt", SENT_CNT, 0);
    chk("mrst_tmo", TMO_ERR, 0);
    @(negedge CLK_25M);
    RST_N = 1'b1;
    #1 chk("mrst_tie_ack", REQ_ACK, 2'b01);
    @(negedge CLK_25M);
    REQ_VLD = 2'b00;
    #1 chk("mrst_tie_txv", TX_VLD, 1);
    chk("mrst_tie_msg", TX_MSG, 8'h34);
    chk("mrst_tie_gnt", GNT_ID, 0);
    @(negedge CLK_25M);
    TX_DNE = 1'b1;
    @(negedge CLK_25M);
    TX_DNE = 1'b0;
    wait_idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
